// File: rtl/weight_tile_loader.sv
// Weight tile loader: issues pipelined in-order Avalon-MM reads for one Tn x Tm x K x K
// weight tile and forwards the returned words to the filter's input stream.
module weight_tile_loader #(
   parameter int AW      = 16,
   parameter int CW      = 16,
   parameter int DW      = 32,
   parameter int N       = 32,
   parameter int M       = 32,
   parameter int Tn      = 16,
   parameter int Tm      = 16,
   parameter int K       = 3,
   parameter int MAX_OUT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] tile_base_m,
   input  logic [CW-1:0] tile_base_n,
   input  logic [AW-1:0] weight_base,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rd_addr,
   output logic          rd_req,
   input  logic          rd_waitrequest,
   input  logic [DW-1:0] rd_data,
   input  logic          rd_data_valid,
   input  logic          fifo_almost_full,
   output logic          fifo_push_tmp,
   output logic [DW-1:0] data_to_fifo_tmp
);

   localparam int TOTAL = Tn * Tm * K * K;
   localparam int XW    = CW + AW;
   localparam int OW    = $clog2(MAX_OUT) + 1;
   localparam int RW    = $clog2(TOTAL + 1);

   localparam logic [CW-1:0] K_LAST  = CW'(K - 1);
   localparam logic [CW-1:0] TM_LAST = CW'(Tm - 1);
   localparam logic [CW-1:0] TN_LAST = CW'(Tn - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] base_m, base_n;
   logic [AW-1:0] wbase;
   logic [CW-1:0] cj, ci, ctm, ctn;
   logic [OW-1:0] outstanding;
   logic [RW-1:0] ret_cnt;

   logic          accept, ret_valid, last_req, can_raise;
   logic [OW-1:0] out_nx;
   logic [CW-1:0] nj, ni, ntm, ntn;
   logic [XW-1:0] m_x, n_x, idx;

   assign accept    = rd_req & ~rd_waitrequest;
   assign ret_valid = rd_data_valid & (outstanding != '0);
   assign last_req  = (cj == K_LAST) && (ci == K_LAST) && (ctm == TM_LAST) && (ctn == TN_LAST);

   always_comb begin
      out_nx = outstanding;
      if (accept && !ret_valid)
         out_nx = outstanding + 1'b1;
      else if (!accept && ret_valid)
         out_nx = outstanding - 1'b1;
   end

   // Counters point at the request being presented; the address of the next
   // request is built from the post-accept coordinates so issue runs at full rate.
   always_comb begin
      nj  = cj;
      ni  = ci;
      ntm = ctm;
      ntn = ctn;
      if (accept) begin
         if (cj == K_LAST) begin
            nj = '0;
            if (ci == K_LAST) begin
               ni = '0;
               if (ctm == TM_LAST) begin
                  ntm = '0;
                  ntn = ctn + 1'b1;
               end else begin
                  ntm = ctm + 1'b1;
               end
            end else begin
               ni = ci + 1'b1;
            end
         end else begin
            nj = cj + 1'b1;
         end
      end
   end

   // Out-of-range channels read a clamped address; the filter zeroes them.
   always_comb begin
      m_x = XW'(base_m) + XW'(ntm);
      n_x = XW'(base_n) + XW'(ntn);
      if (m_x >= XW'(M)) m_x = XW'(M - 1);
      if (n_x >= XW'(N)) n_x = XW'(N - 1);
      idx = ((m_x * XW'(N) + n_x) * XW'(K) + XW'(ni)) * XW'(K) + XW'(nj);
   end

   assign can_raise = (state == ISSUE) && (!rd_req || (accept && !last_req)) &&
                      (out_nx < OW'(MAX_OUT)) && !fifo_almost_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         base_m           <= '0;
         base_n           <= '0;
         wbase            <= '0;
         cj               <= '0;
         ci               <= '0;
         ctm              <= '0;
         ctn              <= '0;
         outstanding      <= '0;
         ret_cnt          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         rd_req           <= 1'b0;
         rd_addr          <= '0;
         fifo_push_tmp    <= 1'b0;
         data_to_fifo_tmp <= '0;
      end else begin
         fifo_push_tmp    <= ret_valid;
         data_to_fifo_tmp <= rd_data;
         outstanding      <= out_nx;
         done             <= 1'b0;
         if (fifo_push_tmp) ret_cnt <= ret_cnt + 1'b1;
         if (accept) begin
            cj  <= nj;
            ci  <= ni;
            ctm <= ntm;
            ctn <= ntn;
         end
         if (can_raise) begin
            rd_req  <= 1'b1;
            rd_addr <= wbase + AW'(idx);
         end else if (accept) begin
            rd_req <= 1'b0;
         end
         case (state)
            IDLE: if (start) begin
               base_m  <= tile_base_m;
               base_n  <= tile_base_n;
               wbase   <= weight_base;
               cj      <= '0;
               ci      <= '0;
               ctm     <= '0;
               ctn     <= '0;
               ret_cnt <= '0;
               busy    <= 1'b1;
               state   <= ISSUE;
            end
            ISSUE: if (accept && last_req) state <= DRAIN;
            DRAIN: if (fifo_push_tmp && ret_cnt == RW'(TOTAL - 1)) begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Randomized bench for weight_tile_loader: in-order memory responder with random stalls
// and latency, plus a loop-nest reference model of the expected word stream.
module tb_weight_tile_loader;

   localparam int AW = 16, CW = 16, DW = 32, N = 32, M = 32, TN = 16, TM = 16, K = 3;
   localparam int MAX_OUT = 8;
   localparam int TOTAL = TN * TM * K * K;

   logic          clk, rst, start;
   logic [CW-1:0] tile_base_m, tile_base_n;
   logic [AW-1:0] weight_base;
   logic          busy, done, rd_req, rd_waitrequest, rd_data_valid;
   logic          fifo_almost_full, fifo_push_tmp;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data, data_to_fifo_tmp;

   weight_tile_loader #(
      .AW(AW), .CW(CW), .DW(DW), .N(N), .M(M), .Tn(TN), .Tm(TM), .K(K), .MAX_OUT(MAX_OUT)
   ) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .tile_base_m(tile_base_m), .tile_base_n(tile_base_n), .weight_base(weight_base),
      .busy(busy), .done(done), .rd_addr(rd_addr), .rd_req(rd_req),
      .rd_waitrequest(rd_waitrequest), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .fifo_almost_full(fifo_almost_full), .fifo_push_tmp(fifo_push_tmp),
      .data_to_fifo_tmp(data_to_fifo_tmp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // scoreboard and monitor state
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] pushes[$];
   logic [AW-1:0] acc_addr[$];
   int            resp_due[$];
   logic [AW-1:0] resp_addr[$];
   int            cyc = 0, last_due = 0, tb_outs = 0, max_outs = 0;
   int            push_cnt = 0, done_cnt = 0, done_cyc = 0, last_push_cyc = 0;
   int            first_acc_cyc = -1, last_acc_cyc = 0, af_raise = 0;
   int            lat_lo = 1, lat_hi = 1;
   logic          stall_en = 1'b0;
   logic [AW-1:0] max_addr = '0;
   logic          prev_req = 1'b0, prev_wait = 1'b0, prev_acc = 1'b0, prev_af = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic          acc;
   int            due;

   // Monitor and memory responder; memory word = its address, returned in request order.
   initial begin
      rd_waitrequest = 1'b0;
      rd_data_valid  = 1'b0;
      rd_data        = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_req = 1'b0; prev_wait = 1'b0; prev_acc = 1'b0; prev_af = 1'b0;
            tb_outs = 0;
            rd_waitrequest = 1'b0;
         end else begin
            if (prev_req && prev_wait) begin
               check("hold_req", rd_req, 1);
               check("hold_addr", rd_addr, prev_addr);
            end
            if (rd_req && (!prev_req || prev_acc) && prev_af) af_raise++;
            if (fifo_push_tmp) begin
               check("push_avail", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) check("push_data", data_to_fifo_tmp, exp_q.pop_front());
               push_cnt++;
               pushes.push_back(data_to_fifo_tmp);
               last_push_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            rd_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            acc = rd_req && !rd_waitrequest;
            if (acc) begin
               tb_outs++;
               due = cyc + int'($urandom_range(lat_lo, lat_hi));
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               resp_due.push_back(due);
               resp_addr.push_back(rd_addr);
               acc_addr.push_back(rd_addr);
               if (first_acc_cyc < 0) first_acc_cyc = cyc;
               last_acc_cyc = cyc;
               if (rd_addr > max_addr) max_addr = rd_addr;
            end
            prev_req = rd_req; prev_wait = rd_waitrequest; prev_acc = acc;
            prev_addr = rd_addr; prev_af = fifo_almost_full;
         end
         // responses already in flight keep arriving even across a reset
         if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
            rd_data_valid = 1'b1;
            rd_data = {{(DW-AW){1'b0}}, resp_addr.pop_front()};
            void'(resp_due.pop_front());
            if (tb_outs > 0) tb_outs--;
         end else begin
            rd_data_valid = 1'b0;
            rd_data = $urandom;
         end
         if (tb_outs > max_outs) max_outs = tb_outs;
      end
   end

   // Reference stream: the tile loop nest with channel clamping and 16-bit address wrap.
   task automatic gen_model(input int bm, input int bn, input int wb);
      int m, n, idx;
      exp_q.delete();
      for (int tn = 0; tn < TN; tn++)
         for (int tm = 0; tm < TM; tm++)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++) begin
                  m = (bm + tm >= M) ? M - 1 : bm + tm;
                  n = (bn + tn >= N) ? N - 1 : bn + tn;
                  idx = ((m * N + n) * K + i) * K + j;
                  exp_q.push_back(DW'((wb + idx) % 65536));
               end
   endtask

   task automatic clear_stats();
      push_cnt = 0; done_cnt = 0; pushes.delete(); acc_addr.delete();
      first_acc_cyc = -1; max_outs = 0; max_addr = '0; af_raise = 0;
   endtask

   task automatic pulse_start(input int bm, input int bn, input int wb);
      tile_base_m = CW'(bm);
      tile_base_n = CW'(bn);
      weight_base = AW'(wb);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_tile(input int bm, input int bn, input int wb, input logic st,
                           input int llo, input int lhi, input logic af_test);
      int af_cyc;
      af_cyc = 0;
      gen_model(bm, bn, wb);
      clear_stats();
      stall_en = st; lat_lo = llo; lat_hi = lhi;
      pulse_start(bm, bn, wb);
      for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
         @(posedge clk); #1;
         if (af_test && push_cnt >= 300 && af_cyc < 100) begin
            fifo_almost_full = 1'b1;
            af_cyc++;
         end else begin
            fifo_almost_full = 1'b0;
         end
      end
      fifo_almost_full = 1'b0;
      check("done_seen", done_cnt > 0, 1);
      repeat (10) @(posedge clk);
      #1;
      check("done_once", done_cnt, 1);
      check("push_count", push_cnt, TOTAL);
      check("exp_left", exp_q.size(), 0);
      check("done_timing", done_cyc, last_push_cyc + 1);
      check("busy_after", busy, 0);
      check("max_outs", max_outs <= MAX_OUT, 1);
      stall_en = 1'b0;
   endtask

   initial begin
      int pcnt;
      rst = 1'b1; start = 1'b0; fifo_almost_full = 1'b0;
      tile_base_m = '0; tile_base_n = '0; weight_base = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_req", rd_req, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_push", fifo_push_tmp, 0);
      check("rst_data", data_to_fifo_tmp, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // plain tile, no stalls, single-cycle latency
      run_tile(0, 0, 'h0100, 1'b0, 1, 1, 1'b0);
      check("push1", pushes[0], 32'h0100);
      check("push2", pushes[1], 32'h0101);
      check("push3", pushes[2], 32'h0102);
      check("push10", pushes[9], 32'h0220);
      check("full_rate", last_acc_cyc - first_acc_cyc, TOTAL - 1);

      // clamped channels with random stalls and latency
      run_tile(24, 24, 'h0100, 1'b1, 1, 6, 1'b0);
      check("max_addr", max_addr, ((31 * 32 + 31) * K + 2) * K + 2 + 'h100);

      // backpressure window mid-tile
      run_tile(0, 0, 'h0200, 1'b1, 1, 6, 1'b1);
      check("af_no_raise", af_raise, 0);

      // start while busy is ignored, then reset mid-tile
      gen_model(0, 0, 'h0100);
      clear_stats();
      stall_en = 1'b1; lat_lo = 1; lat_hi = 6;
      pulse_start(0, 0, 'h0100);
      repeat (20) @(posedge clk);
      #1;
      pulse_start(8, 4, 'h5000);
      for (int c = 0; c < 5000 && push_cnt < 500; c++) begin
         @(posedge clk); #1;
      end
      check("reached_500", push_cnt >= 500, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_req", rd_req, 0);
      check("arst_addr", rd_addr, 0);
      check("arst_push", fifo_push_tmp, 0);
      check("arst_data", data_to_fifo_tmp, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      pcnt = push_cnt;
      repeat (30) @(posedge clk);
      #1;
      check("no_push_after_rst", push_cnt, pcnt);
      check("idle_after_rst", busy, 0);
      run_tile(0, 0, 'h0100, 1'b1, 1, 6, 1'b0);

      // address wrap modulo 2^16
      run_tile(0, 0, 'hFFF0, 1'b0, 1, 3, 1'b0);
      check("wrap_req5", acc_addr[4], 16'hFFF4);
      check("wrap_idx16", acc_addr[TM * K * K + 7], 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_tile_loader.md
Name: weight_tile_loader

Overview:
- Upstream feeder of the weight filter stage: for one weight tile (Tn x Tm x K x K words) it issues pipelined Avalon-MM reads to external weight memory.
- Returned words are pushed as a stream (fifo_push_tmp / data_to_fifo_tmp) in the order the filter's nest4 counter expects: j innermost, then i, then tm, with tn outermost.
- Out-of-range channels are read from clamped addresses; zeroing them is the filter's job.

Parameters:
- AW, 16, memory word-address width
- CW, 16, counter/coordinate width
- DW, 32, data width
- N, 32, total input channels
- M, 32, total output channels
- Tn, 16, tile input channels
- Tm, 16, tile output channels
- K, 3, kernel size
- MAX_OUT, 8, maximum outstanding read requests (power of 2, at least 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse that starts a tile load; ignored unless IDLE
- tile_base_m  in  CW  first output channel of tile; sampled on accepted start
- tile_base_n  in  CW  first input channel of tile; sampled on accepted start
- weight_base  in  AW  word address of W[0][0][0][0]; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word of the tile has been pushed
- rd_addr  out  AW  Avalon read word address
- rd_req  out  1  Avalon read request
- rd_waitrequest  in  1  Avalon stall
- rd_data  in  DW  Avalon read data
- rd_data_valid  in  1  Avalon read data valid
- fifo_almost_full  in  1  downstream backpressure
- fifo_push_tmp  out  1  stream valid (to filter)
- data_to_fifo_tmp  out  DW  stream data (to filter)

Behaviour:
- Reset rst: asynchronous, active-high. Clock clk. All outputs reset to 0; state resets to IDLE; all counters reset to 0.
- Memory layout: W[m][n][i][j], word index ((m*N+n)*K+i)*K+j. rd_addr = weight_base + index, truncated modulo 2^AW.
- Coordinates: m = tile_base_m + tm, n = tile_base_n + tn.
  - If m >= M, use M-1 in the address; if n >= N, use N-1.
  - Computation in CW+AW-wide intermediates, no overflow before truncation.
- Issue order: request counter over j (0..K-1), i, tm (0..Tm-1), tn (0..Tn-1), j fastest. The counter advances only on an accepted request (rd_req and not rd_waitrequest).
- States:
  - IDLE: accepted start latches inputs and goes to ISSUE.
  - ISSUE: issues requests. After the accept of request number TOTAL-1 (TOTAL = Tn*Tm*K*K), goes to DRAIN.
  - DRAIN: waits for the return counter to reach TOTAL, then goes to DONE.
  - DONE: single cycle, then IDLE.
- busy is high in ISSUE, DRAIN and DONE.
- Request rules:
  - rd_req and rd_addr are registered.
  - While rd_req is high and rd_waitrequest is high, rd_req and rd_addr stay stable.
  - A new request is raised only if outstanding < MAX_OUT (counting a request accepted this cycle) and fifo_almost_full is low.
  - A request already presented is not withdrawn when fifo_almost_full rises.
  - At most one request per cycle; back-to-back issue at full rate when unstalled.
- Outstanding counter:
  - +1 on accept, -1 on rd_data_valid, unchanged when both occur.
  - Never exceeds MAX_OUT; never underflows.
  - A rd_data_valid arriving with outstanding = 0 is ignored.
- Return path: fifo_push_tmp <= rd_data_valid (when outstanding > 0) and data_to_fifo_tmp <= rd_data, one-cycle latency. Data order equals request order (Avalon in-order).
- Return counter increments on each push. done pulses in the cycle after the TOTAL-th fifo_push_tmp. Exactly TOTAL pushes per tile.
- start while busy: ignored, latched values unchanged.
- Reset mid-tile: everything aborts to IDLE. Late rd_data_valid after reset is ignored because outstanding = 0.

Test Plan:
- Defaults, weight_base=0x0100, tile_base_m=0, tile_base_n=0, memory word = address, no stalls -> 2304 pushes. First data 0x0100, then 0x0101, 0x0102; push 10 = word at ((1*32+0)*3+0)*3+0+0x100 = 0x0220. done exactly once, one cycle after the last push. Steady-state 1 request per cycle.
- tile_base_m=16, tile_base_n=16, M=N=24 -> tm>=8 or tn>=8 use m=23 or n=23 addresses. No rd_addr beyond (23*24+23)*9+8+base. 2304 pushes.
- Random rd_waitrequest (50%) and read latency 1..6 -> rd_addr/rd_req stable during stalls, outstanding never above 8, stream order identical to the no-stall run.
- Hold fifo_almost_full high for 100 cycles mid-tile -> no new rd_req raised after in-flight reads complete. Load resumes on release with no duplicates or lost words.
- start pulse while busy, then rst asserted at push 500 -> second start ignored. Reset forces outputs to 0 and IDLE. A new start loads a full 2304-word tile correctly.
- weight_base=0xFFF0 -> addresses wrap modulo 2^16. Fifth request is 0xFFF4, index 16 is 0x0000.
